// File: rtl/alut_age_checker25.sv
// Address-table age sweeper: walks every entry, invalidates those older than
// best_bfr_age25, and yields to the add path whenever both touch the same entry.
module alut_age_checker25 #(
  parameter int DW25 = 83,
  parameter int DD25 = 256
) (
  input  logic            pclk25,
  input  logic            n_p_reset25,
  input  logic            check_age25,
  input  logic [31:0]     best_bfr_age25,
  input  logic [31:0]     curr_time25,
  input  logic [7:0]      mem_addr_add25,
  input  logic            mem_write_add25,
  input  logic [DW25-1:0] mem_read_data_age25,
  output logic [7:0]      mem_addr_age25,
  output logic            mem_write_age25,
  output logic [DW25-1:0] mem_write_data_age25,
  output logic            age_busy25,
  output logic            age_done25,
  output logic [8:0]      aged_count25
);

  typedef enum logic [2:0] {IDLE, RD, CHK, WR, DONE} state_t;

  state_t          state;
  logic [7:0]      addr;
  logic            coll_q;
  logic [DW25-1:0] wdata;
  logic [8:0]      count;
  logic            busy;
  logic            done;

  logic [31:0] ts;
  logic [31:0] age;
  logic        aged;
  logic        add_hit;
  logic        last;

  // Age is a modulo-2^32 difference so a wrapped time stamp still ages correctly.
  assign ts      = mem_read_data_age25[81:50];
  assign age     = curr_time25 - ts;
  assign aged    = mem_read_data_age25[82] && (age > best_bfr_age25);
  assign add_hit = mem_write_add25 && (mem_addr_add25 == addr);
  assign last    = (addr == 8'(DD25 - 1));

  assign mem_addr_age25       = addr;
  assign mem_write_age25      = (state == WR) && !add_hit;
  assign mem_write_data_age25 = wdata;
  assign age_busy25           = busy;
  assign age_done25           = done;
  assign aged_count25         = count;

  always_ff @(posedge pclk25 or negedge n_p_reset25) begin
    if (!n_p_reset25) begin
      state  <= IDLE;
      addr   <= '0;
      coll_q <= 1'b0;
      wdata  <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (check_age25) begin
            state  <= RD;
            addr   <= '0;
            count  <= '0;
            coll_q <= 1'b0;
            busy   <= 1'b1;
          end
        end
        RD: begin
          coll_q <= coll_q | add_hit;
          state  <= CHK;
        end
        CHK: begin
          if (aged && !coll_q && !add_hit) begin
            state     <= WR;
            wdata     <= mem_read_data_age25;
            wdata[82] <= 1'b0;
          end else begin
            coll_q <= 1'b0;
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              addr  <= addr + 8'd1;
              state <= RD;
            end
          end
        end
        WR: begin
          // A simultaneous add-path write owns the entry; the age write is dropped.
          if (!add_hit) count <= count + 9'd1;
          coll_q <= 1'b0;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            addr  <= addr + 8'd1;
            state <= RD;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
